axi_wid_tracker: RTL and testbench
==================================

# axi_wid_tracker

Write-ID regenerator for AXI4-to-AXI3 bridging with burst tracking and flow control. It records {AWID, AWLEN} of every accepted write address in an in-order FIFO. It drives WID and a regenerated WLAST on the outgoing W channel, and checks the incoming WLAST against the recorded burst length. The block sits in-line on the AW and W channels between an AXI4 master port and an AXI3 slave port. It back-pressures AW when the FIFO is full and back-pressures W until a matching address has been recorded.

## Interface
- WIDTH_ID, 4, ID width in bits.
- WIDTH_LEN, 8, burst-length field width (beats = AWLEN+1).
- FAW, 2, FIFO address width; depth = 2**FAW entries; FAW >= 1.

Ports. Clock and reset: one clock; reset is asynchronous and active-low (ARESETn, ACLK).
- ARESETn  in  1  asynchronous active-low reset
- ACLK  in  1  clock, rising edge
- S_AWID  in  WIDTH_ID  upstream write-address ID
- S_AWLEN  in  WIDTH_LEN  upstream burst length
- S_AWVALID  in  1  upstream AW valid
- S_AWREADY  out  1  upstream AW ready
- M_AWVALID  out  1  downstream AW valid (ID/LEN/addr pass around this block)
- M_AWREADY  in  1  downstream AW ready
- S_WLAST  in  1  upstream WLAST, checked only
- S_WVALID  in  1  upstream W valid
- S_WREADY  out  1  upstream W ready
- M_WID  out  WIDTH_ID  regenerated write ID
- M_WLAST  out  1  regenerated WLAST
- M_WVALID  out  1  downstream W valid
- M_WREADY  in  1  downstream W ready
- ERR_WLAST  out  1  sticky WLAST-mismatch flag
- ITEM_CNT  out  FAW+1  outstanding write bursts held in the FIFO

## Operation
- **AW gating (combinational).**
  - M_AWVALID = S_AWVALID & ~full.
  - S_AWREADY = M_AWREADY & ~full.
  - push = S_AWVALID & S_AWREADY; it writes {S_AWID, S_AWLEN} at the tail.
- **W gating (combinational).**
  - M_WVALID = S_WVALID & ~empty.
  - S_WREADY = M_WREADY & ~empty.
  - beat = M_WVALID & M_WREADY.
- **Head-entry outputs.**
  - M_WID = head ID when ~empty, else 0.
  - M_WLAST = (beat_cnt == head LEN) & ~empty.
- **Beat counter.** beat_cnt is WIDTH_LEN bits.
  - On a beat with M_WLAST=1: clears to 0 and pops the head.
  - On any other beat: increments.
  - Otherwise: holds.
- **Length check.** On every beat where S_WLAST != M_WLAST, ERR_WLAST sets to 1. It is cleared only by reset.
  - The downstream beat is still forwarded using the regenerated M_WLAST. The burst is never truncated or extended by upstream WLAST.
- **No bypass.** A W beat is never matched to an AW in the same cycle that AW is accepted. W stalls while the FIFO is empty.
- **Pointers.** rd/wr pointers are FAW+1 bits, so wrap-around is distinguished by the MSB.
  - full = (ITEM_CNT == 2**FAW).
  - empty = (ITEM_CNT == 0).
- **Simultaneous push and pop.** Both occur in the same cycle; ITEM_CNT is unchanged.
  - Push while full cannot occur, because S_AWREADY=0.
  - Pop while empty cannot occur, because S_WREADY=0.

## Timing
- **Reset values** (ARESETn low, asynchronous):
  - Pointers, ITEM_CNT, beat_cnt and ERR_WLAST are all 0.
  - Hence M_WVALID=0, S_WREADY=0, M_WID=0, M_WLAST=0.
  - M_AWVALID follows S_AWVALID, and S_AWREADY follows M_AWREADY.
- **Reset mid-burst:** all outstanding entries and the partial beat count are discarded. No output glitch is required beyond the combinational follow.
- **Latencies:**
  - AW accepted at edge N makes the entry visible at head (if the FIFO was empty) after edge N. The first W beat can complete at edge N+1 at the earliest.
  - Pop at edge N: the next head's ID/LEN appear on M_WID/M_WLAST after edge N. Back-to-back bursts incur no bubble.
  - Full deasserts after the pop edge, so S_AWREADY can rise in the cycle following a pop.
- All ready/valid paths are combinational from inputs. There are no registered outputs except ERR_WLAST and ITEM_CNT.

## Test plan
- **Single burst.** AW ID=0x5, LEN=3, then 4 W beats with S_WLAST on the 4th.
  - M_WID=0x5 on all 4 beats.
  - M_WLAST=1 only on beat 4.
  - ITEM_CNT goes 1 then 0; ERR_WLAST=0.
- **Full back-pressure.** FAW=2: 4 AWs (IDs 1,2,3,4, LEN=0) with no W.
  - ITEM_CNT=4 and S_AWREADY=M_AWVALID=0 while the 5th AW (ID 6) is held.
  - One W beat (M_WID=1) follows, then the 5th AW is accepted next cycle; IDs then drain in order 2,3,4,6.
- **W before AW.** S_WVALID=1 with the FIFO empty.
  - S_WREADY=M_WVALID=0 until the cycle after an AW handshake (ID=0xA, LEN=0).
  - The beat then completes with M_WID=0xA and M_WLAST=1.
- **WLAST mismatch.** AW LEN=1, upstream asserts S_WLAST on beat 1.
  - ERR_WLAST=1 from the next edge.
  - M_WLAST=0 on beat 1 and 1 on beat 2, then the head pops.
  - ERR_WLAST stays 1 until reset.
- **Simultaneous push/pop.** With ITEM_CNT=2, a final W beat and an AW handshake occur in the same cycle.
  - ITEM_CNT stays 2.
  - The new ID is served after the intervening entry.
  - Repeat across pointer wrap (more than 8 bursts, FAW=2) with IDs checked in order.
- **Reset mid-burst.** Deassert ARESETn after beat 2 of a LEN=3 burst.
  - ITEM_CNT=0, M_WVALID=0, ERR_WLAST=0 immediately.
  - After release, a new LEN=0 burst completes with the correct ID.

Source files
------------

// File: rtl/axi_wid_tracker.sv
// Write-ID regenerator for AXI4-to-AXI3 bridging: records {AWID, AWLEN} in order,
// drives WID and a regenerated WLAST downstream, and flags upstream WLAST mismatches.
module axi_wid_tracker #(
  parameter int unsigned WIDTH_ID  = 4,
  parameter int unsigned WIDTH_LEN = 8,
  parameter int unsigned FAW       = 2
) (
  input  logic                 ARESETn,
  input  logic                 ACLK,
  input  logic [WIDTH_ID-1:0]  S_AWID,
  input  logic [WIDTH_LEN-1:0] S_AWLEN,
  input  logic                 S_AWVALID,
  output logic                 S_AWREADY,
  output logic                 M_AWVALID,
  input  logic                 M_AWREADY,
  input  logic                 S_WLAST,
  input  logic                 S_WVALID,
  output logic                 S_WREADY,
  output logic [WIDTH_ID-1:0]  M_WID,
  output logic                 M_WLAST,
  output logic                 M_WVALID,
  input  logic                 M_WREADY,
  output logic                 ERR_WLAST,
  output logic [FAW:0]         ITEM_CNT
);

  localparam int unsigned DEPTH = 2 ** FAW;

  logic [FAW:0]           wr_ptr_q, rd_ptr_q;
  logic [FAW:0]           item_cnt;
  logic [WIDTH_ID-1:0]    id_mem_q  [DEPTH];
  logic [WIDTH_LEN-1:0]   len_mem_q [DEPTH];
  logic [WIDTH_LEN-1:0]   beat_cnt_q, beat_cnt_d;
  logic                   err_q, err_d;
  logic                   full, empty;
  logic                   push, beat, pop;
  logic [WIDTH_ID-1:0]    head_id;
  logic [WIDTH_LEN-1:0]   head_len;

  // Extra pointer MSB separates full from empty when the low bits match.
  assign item_cnt = wr_ptr_q - rd_ptr_q;
  assign full     = (item_cnt == (FAW + 1)'(DEPTH));
  assign empty    = (item_cnt == '0);

  assign M_AWVALID = S_AWVALID & ~full;
  assign S_AWREADY = M_AWREADY & ~full;
  assign push      = S_AWVALID & S_AWREADY;

  assign head_id  = id_mem_q[rd_ptr_q[FAW-1:0]];
  assign head_len = len_mem_q[rd_ptr_q[FAW-1:0]];

  // W is held off while empty, so a beat never pairs with an AW accepted the same cycle.
  assign M_WVALID = S_WVALID & ~empty;
  assign S_WREADY = M_WREADY & ~empty;
  assign beat     = M_WVALID & M_WREADY;

  assign M_WID   = empty ? '0 : head_id;
  assign M_WLAST = ~empty & (beat_cnt_q == head_len);
  assign pop     = beat & M_WLAST;

  assign ERR_WLAST = err_q;
  assign ITEM_CNT  = item_cnt;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    if (beat) begin
      beat_cnt_d = M_WLAST ? '0 : beat_cnt_q + 1'b1;
      if (S_WLAST != M_WLAST) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge ACLK) begin
    if (push) begin
      id_mem_q[wr_ptr_q[FAW-1:0]]  <= S_AWID;
      len_mem_q[wr_ptr_q[FAW-1:0]] <= S_AWLEN;
    end
  end

endmodule

// File: tb/tb_axi_wid_tracker.sv
// Randomised and directed bench for axi_wid_tracker, checked every cycle against a
// queue-based model of outstanding bursts plus literal expectations for directed cases.
module tb_axi_wid_tracker;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] s_awid = '0;
  logic [7:0] s_awlen = '0;
  logic       s_awvalid = 1'b0;
  logic       s_awready;
  logic       m_awvalid;
  logic       m_awready = 1'b0;
  logic       s_wlast = 1'b0;
  logic       s_wvalid = 1'b0;
  logic       s_wready;
  logic [3:0] m_wid;
  logic       m_wlast;
  logic       m_wvalid;
  logic       m_wready = 1'b0;
  logic       err_wlast;
  logic [2:0] item_cnt;

  int checks = 0;
  int errors = 0;

  axi_wid_tracker #(.WIDTH_ID(4), .WIDTH_LEN(8), .FAW(2)) dut (
    .ARESETn  (rst_n),
    .ACLK     (clk),
    .S_AWID   (s_awid),
    .S_AWLEN  (s_awlen),
    .S_AWVALID(s_awvalid),
    .S_AWREADY(s_awready),
    .M_AWVALID(m_awvalid),
    .M_AWREADY(m_awready),
    .S_WLAST  (s_wlast),
    .S_WVALID (s_wvalid),
    .S_WREADY (s_wready),
    .M_WID    (m_wid),
    .M_WLAST  (m_wlast),
    .M_WVALID (m_wvalid),
    .M_WREADY (m_wready),
    .ERR_WLAST(err_wlast),
    .ITEM_CNT (item_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] id;
    logic [7:0] len;
  } ent_t;

  // Model: list of outstanding bursts, beats already sent of the head burst, sticky error.
  ent_t        mq[$];
  int unsigned mbeats = 0;
  logic        merr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare at negedge, then advance the model by what the next posedge will do.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        mbeats = 0;
        merr   = 1'b0;
      end
      begin
        bit is_full, is_empty, push, bt, last;
        is_full  = (mq.size() == DEPTH);
        is_empty = (mq.size() == 0);
        last     = !is_empty && (mbeats == int'(mq[0].len));
        chk("m_awvalid", 32'(m_awvalid), 32'(s_awvalid && !is_full));
        chk("s_awready", 32'(s_awready), 32'(m_awready && !is_full));
        chk("m_wvalid", 32'(m_wvalid), 32'(s_wvalid && !is_empty));
        chk("s_wready", 32'(s_wready), 32'(m_wready && !is_empty));
        chk("m_wid", 32'(m_wid), is_empty ? 32'd0 : 32'(mq[0].id));
        chk("m_wlast", 32'(m_wlast), 32'(last));
        chk("err_wlast", 32'(err_wlast), 32'(merr));
        chk("item_cnt", 32'(item_cnt), 32'(mq.size()));
        if (rst_n) begin
          push = s_awvalid && m_awready && !is_full;
          bt   = s_wvalid && m_wready && !is_empty;
          if (bt) begin
            if (s_wlast != last) merr = 1'b1;
            if (last) begin
              void'(mq.pop_front());
              mbeats = 0;
            end else begin
              mbeats++;
            end
          end
          if (push) mq.push_back({s_awid, s_awlen});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic aw(input logic [3:0] id, input logic [7:0] len);
    s_awvalid = 1'b1;
    s_awid    = id;
    s_awlen   = len;
  endtask

  initial begin
    m_awready = 1'b1;
    m_wready  = 1'b1;
    #1;
    chk("rst item_cnt", 32'(item_cnt), 32'd0);
    chk("rst m_wvalid", 32'(m_wvalid), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single burst
    aw(4'h5, 8'd3);
    step();
    s_awvalid = 1'b0;
    chk("single cnt1", 32'(item_cnt), 32'd1);
    s_wvalid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      s_wlast = (b == 3);
      chk("single wid", 32'(m_wid), 32'h5);
      chk("single wlast", 32'(m_wlast), 32'(b == 3));
      step();
    end
    s_wvalid = 1'b0;
    s_wlast  = 1'b0;
    chk("single cnt0", 32'(item_cnt), 32'd0);
    chk("single err", 32'(err_wlast), 32'd0);

    // Full back-pressure
    for (int i = 1; i <= 4; i++) begin
      aw(4'(i), 8'd0);
      step();
    end
    aw(4'h6, 8'd0);
    chk("full cnt", 32'(item_cnt), 32'd4);
    chk("full awready", 32'(s_awready), 32'd0);
    chk("full awvalid", 32'(m_awvalid), 32'd0);
    step();
    s_wvalid = 1'b1;
    s_wlast  = 1'b1;
    chk("full first wid", 32'(m_wid), 32'h1);
    chk("full held awready", 32'(s_awready), 32'd0);
    step();
    s_wvalid = 1'b0;
    chk("full cnt3", 32'(item_cnt), 32'd3);
    chk("full awready rises", 32'(s_awready), 32'd1);
    step();
    s_awvalid = 1'b0;
    chk("full refill", 32'(item_cnt), 32'd4);
    s_wvalid = 1'b1;
    begin
      logic [3:0] order [4] = '{4'h2, 4'h3, 4'h4, 4'h6};
      for (int i = 0; i < 4; i++) begin
        chk("full drain wid", 32'(m_wid), 32'(order[i]));
        step();
      end
    end
    s_wvalid = 1'b0;
    chk("full drained", 32'(item_cnt), 32'd0);

    // W before AW
    s_wvalid = 1'b1;
    chk("wfirst wready", 32'(s_wready), 32'd0);
    chk("wfirst wvalid", 32'(m_wvalid), 32'd0);
    step();
    aw(4'hA, 8'd0);
    chk("wfirst no bypass", 32'(s_wready), 32'd0);
    step();
    s_awvalid = 1'b0;
    chk("wfirst valid", 32'(m_wvalid), 32'd1);
    chk("wfirst wid", 32'(m_wid), 32'hA);
    chk("wfirst wlast", 32'(m_wlast), 32'd1);
    step();
    s_wvalid = 1'b0;
    chk("wfirst cnt", 32'(item_cnt), 32'd0);

    // Simultaneous push and pop
    aw(4'h7, 8'd1);
    step();
    aw(4'h8, 8'd0);
    step();
    s_awvalid = 1'b0;
    chk("simul cnt2", 32'(item_cnt), 32'd2);
    s_wvalid = 1'b1;
    s_wlast  = 1'b0;
    chk("simul wid7", 32'(m_wid), 32'h7);
    step();
    s_wlast = 1'b1;
    aw(4'h9, 8'd0);
    chk("simul wlast", 32'(m_wlast), 32'd1);
    step();
    s_awvalid = 1'b0;
    chk("simul cnt kept", 32'(item_cnt), 32'd2);
    chk("simul wid8", 32'(m_wid), 32'h8);
    step();
    chk("simul wid9", 32'(m_wid), 32'h9);
    step();
    s_wvalid = 1'b0;

    // Push/pop every cycle across several pointer wraps
    aw(4'h1, 8'd0);
    step();
    aw(4'h2, 8'd0);
    step();
    s_wvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      aw(4'(i + 3), 8'd0);
      chk("wrap wid", 32'(m_wid), 32'(i + 1));
      chk("wrap cnt", 32'(item_cnt), 32'd2);
      step();
    end
    s_awvalid = 1'b0;
    chk("wrap tail11", 32'(m_wid), 32'hB);
    step();
    chk("wrap tail12", 32'(m_wid), 32'hC);
    step();
    s_wvalid = 1'b0;

    // WLAST mismatch
    aw(4'h5, 8'd1);
    step();
    s_awvalid = 1'b0;
    s_wvalid  = 1'b1;
    s_wlast   = 1'b1;
    chk("mis wlast beat1", 32'(m_wlast), 32'd0);
    chk("mis err before", 32'(err_wlast), 32'd0);
    step();
    chk("mis err set", 32'(err_wlast), 32'd1);
    chk("mis wlast beat2", 32'(m_wlast), 32'd1);
    step();
    s_wvalid = 1'b0;
    repeat (3) step();
    chk("mis err sticky", 32'(err_wlast), 32'd1);
    chk("mis popped", 32'(item_cnt), 32'd0);

    // Reset mid-burst
    aw(4'hC, 8'd3);
    step();
    s_awvalid = 1'b0;
    s_wvalid  = 1'b1;
    s_wlast   = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("rmid cnt", 32'(item_cnt), 32'd0);
    chk("rmid wvalid", 32'(m_wvalid), 32'd0);
    chk("rmid err", 32'(err_wlast), 32'd0);
    @(negedge clk);
    step();
    rst_n    = 1'b1;
    s_wvalid = 1'b0;
    aw(4'h3, 8'd0);
    step();
    s_awvalid = 1'b0;
    s_wvalid  = 1'b1;
    s_wlast   = 1'b1;
    chk("rmid new wid", 32'(m_wid), 32'h3);
    chk("rmid new wlast", 32'(m_wlast), 32'd1);
    step();
    s_wvalid = 1'b0;

    // Random traffic; upstream WLAST follows the model except for rare deliberate errors
    for (int c = 0; c < 600; c++) begin
      s_awvalid = ($urandom_range(0, 2) != 0);
      s_awid    = 4'($urandom);
      s_awlen   = 8'($urandom_range(0, 3));
      m_awready = ($urandom_range(0, 3) != 0);
      s_wvalid  = ($urandom_range(0, 3) != 0);
      m_wready  = ($urandom_range(0, 3) != 0);
      if (mq.size() != 0) s_wlast = (mbeats == int'(mq[0].len));
      else s_wlast = 1'($urandom);
      if (c > 400 && $urandom_range(0, 29) == 0) s_wlast = ~s_wlast;
      step();
    end
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
